fifo_write_ctrl: RTL

//  Write-side pointer/flag controller of the async FIFO, write clock domain.
//  - Advances the binary write pointer on accepted writes and drives the memory write address/enable.
//  - Publishes a registered Gray write pointer to the read-domain synchroniser.
//  - Derives full, almost_full and fill level from the synchronised read Gray pointer.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_gray2bin.sv | 19 +
 rtl/fifo_write_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared async-FIFO sizing defaults, pointer type and Gray/binary helpers.
// Rev 1.0
`default_nettype none

package fifo_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int AF_THRESH  = 12;

  typedef logic [ADDR_WIDTH:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin[ADDR_WIDTH] = gray[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_gray2bin.sv
// fifo_gray2bin: combinational Gray-to-binary converter of parameterised width.
// Rev 1.0
`default_nettype none

module fifo_gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of its Gray bit and every more-significant Gray bit.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

`default_nettype wire

// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl: write-domain pointer, full/almost_full and level controller of the async FIFO.
// Optional sticky overflow port with FIFO_WR_OVERFLOW_EN. Rev 1.0
`default_nettype none

module fifo_write_ctrl #(
  parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
  parameter int AF_THRESH  = fifo_pkg::AF_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_gr_ptr_sync,
  output logic                  wr_mem_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_gray_ptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level
`ifdef FIFO_WR_OVERFLOW_EN
  ,
  output logic                  overflow
`endif
);

  localparam int A = ADDR_WIDTH;
  localparam logic [A:0] c_af_level = (A+1)'(AF_THRESH);

  logic [A:0] wr_bin_q, wr_bin_d;
  logic [A:0] wr_gray_q, wr_gray_d;
  logic [A:0] wr_level_q, wr_level_d;
  logic       full_q, full_d;
  logic       almost_full_q, almost_full_d;
  logic [A:0] rd_bin_sync;
  logic       accept;

  fifo_gray2bin #(.W(A+1)) u_rd_gray2bin (
    .gray (rd_gr_ptr_sync),
    .bin  (rd_bin_sync)
  );

  always_comb begin
    accept        = wr_en && !full_q;
    wr_bin_d      = wr_bin_q + {{A{1'b0}}, accept};
    wr_gray_d     = wr_bin_d ^ (wr_bin_d >> 1);
    // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
    full_d        = (wr_gray_d == {~rd_gr_ptr_sync[A:A-1], rd_gr_ptr_sync[A-2:0]});
    wr_level_d    = wr_bin_d - rd_bin_sync;
    almost_full_d = (wr_level_d >= c_af_level);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bin_q      <= '0;
      wr_gray_q     <= '0;
      wr_level_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_bin_q      <= wr_bin_d;
      wr_gray_q     <= wr_gray_d;
      wr_level_q    <= wr_level_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
    end
  end

`ifdef FIFO_WR_OVERFLOW_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q | (wr_en && full_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`endif

  // The strobe is combinational, so it must be explicitly masked while reset is held.
  assign wr_mem_en   = accept && !rst;
  assign wr_addr     = wr_bin_q[A-1:0];
  assign wr_gray_ptr = wr_gray_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign wr_level    = wr_level_q;

endmodule

`default_nettype wire
